// File: rtl/estimator_pkg.sv
// rtl/estimator_pkg.sv - shared constants, state encoding and saturation helper for the estimator
package estimator_pkg;

  localparam logic [31:0] MATCH_CALCULATE = 32'h0000_2027;
  localparam logic [31:0] MASK_CALCULATE  = 32'hfe00_707f;

  // Width of the saturator input; datapath sums are sign-extended to this width first.
  localparam int SAT_IN_W = 64;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 64'sd2147483647;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -64'sd2147483648;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // Clamp a signed sum into the 32-bit two's-complement range.
  function automatic logic [31:0] sat32(input logic signed [SAT_IN_W-1:0] v);
    if (v > SAT_MAX) begin
      return 32'h7fff_ffff;
    end else if (v < SAT_MIN) begin
      return 32'h8000_0000;
    end else begin
      return v[31:0];
    end
  endfunction

endpackage

// File: rtl/pcpi_estimator_sequencer.sv
// rtl/pcpi_estimator_sequencer.sv - PCPI controller sequencing the LUT adder-tree estimator
module pcpi_estimator_sequencer
  import estimator_pkg::*;
#(
  parameter int NUM_ADD_CLK      = 4,
  parameter int NUM_ADDER_STAGES = 6,
  parameter int SUM_WIDTH        = 34,
  localparam int SEL_W = (NUM_ADD_CLK > 1) ? $clog2(NUM_ADD_CLK) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pcpi_valid,
  input  logic [31:0]                 pcpi_insn,
  input  logic [31:0]                 pcpi_rs1,
  input  logic [31:0]                 pcpi_rs2,
  output logic                        pcpi_wr,
  output logic [31:0]                 pcpi_rd,
  output logic                        pcpi_wait,
  output logic                        pcpi_ready,
  output logic [31:0]                 dp_ctrl_word,
  output logic                        dp_ctrl_load,
  output logic                        dp_acc_clear,
  output logic                        dp_issue,
  output logic [SEL_W-1:0]            dp_batch_sel,
  input  logic signed [SUM_WIDTH-1:0] dp_sum,
  output logic [31:0]                 calc_count,
  output logic                        busy
);

  // One down-counter serves both the issue batches and the pipeline drain.
  localparam int CNT_MAX = (NUM_ADD_CLK > NUM_ADDER_STAGES) ? NUM_ADD_CLK : NUM_ADDER_STAGES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ISSUE_RELOAD = CNT_W'(NUM_ADD_CLK - 1);
  localparam logic [CNT_W-1:0] DRAIN_RELOAD = CNT_W'(NUM_ADDER_STAGES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL     = SEL_W'(NUM_ADD_CLK - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           ctrl_word_q, ctrl_word_d;
  logic [31:0]           rd_q, rd_d;
  logic [31:0]           count_q, count_d;
  logic                  wait_q, wait_d;

  logic                  insn_match;
  logic                  cnt_done;
  logic signed [SAT_IN_W-1:0] sum_ext;
  logic                  unused_rs2;

  assign insn_match = pcpi_valid && ((pcpi_insn & MASK_CALCULATE) == MATCH_CALCULATE);
  assign cnt_done   = (cnt_q == '0);
  assign sum_ext    = SAT_IN_W'(dp_sum);
  assign unused_rs2 = ^pcpi_rs2;

  // State register plus all sequencer/datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ctrl_word_q <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      wait_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_word_q <= ctrl_word_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
    end
  end

  // Next-state logic; any loss of pcpi_valid before RESP aborts back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (insn_match) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
          cnt_d   = ISSUE_RELOAD;
        end
      end
      ST_ISSUE: begin
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_done) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_RELOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_done) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!pcpi_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register next values: control word latch, result capture, counter, registered wait.
  always_comb begin
    ctrl_word_d = ctrl_word_q;
    rd_d        = rd_q;
    count_d     = count_q;
    if (state_q == ST_IDLE && insn_match) ctrl_word_d = pcpi_rs1;
    if (state_q == ST_DRAIN && pcpi_valid && cnt_done) rd_d = sat32(sum_ext);
    if (state_q == ST_RESP) count_d = count_q + 32'd1;
    wait_d = (state_d == ST_LOAD) || (state_d == ST_ISSUE) ||
             (state_d == ST_DRAIN) || (state_d == ST_RESP);
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    dp_ctrl_load = (state_q == ST_LOAD);
    dp_acc_clear = (state_q == ST_LOAD);
    dp_issue     = (state_q == ST_ISSUE);
    dp_batch_sel = (state_q == ST_ISSUE) ? (LAST_SEL - SEL_W'(cnt_q)) : '0;
    pcpi_ready   = (state_q == ST_RESP);
    pcpi_wr      = (state_q == ST_RESP);
    busy         = (state_q != ST_IDLE);
    pcpi_wait    = wait_q;
    pcpi_rd      = rd_q;
    dp_ctrl_word = ctrl_word_q;
    calc_count   = count_q;
  end

endmodule
